// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine. Transforms COLS_PER_CYCLE
// columns per BUSY cycle; the 4-bit round header rides alongside the state.

module mix_col (
    input  logic        inv_i,
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [3:0][7:0] a, m2, m3, m4, m8, m9, mb, md, me;

    genvar r;
    for (r = 0; r < 4; r++) begin : g_row
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;
        assign a[r]  = col_i[r*8 +: 8];
        assign m2[r] = xt(a[r]);
        assign m4[r] = xt(m2[r]);
        assign m8[r] = xt(m4[r]);
        assign m3[r] = m2[r] ^ a[r];
        assign m9[r] = m8[r] ^ a[r];
        assign mb[r] = m8[r] ^ m2[r] ^ a[r];
        assign md[r] = m8[r] ^ m4[r] ^ a[r];
        assign me[r] = m8[r] ^ m4[r] ^ m2[r];
        // Row r uses row 0's coefficients rotated right by r.
        assign col_o[r*8 +: 8] = inv_i ? (me[r] ^ mb[R1] ^ md[R2] ^ m9[R3])
                                       : (m2[r] ^ m3[R1] ^ a[R2] ^ a[R3]);
    end
endmodule

module mix_columns_iter #(
    parameter int         COLS_PER_CYCLE = 1,
    parameter logic [3:0] BYPASS_HDR     = 4'd10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [131:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [131:0] out_data,
    output logic         busy
);
    localparam int N = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [3:0]   hdr_q, hdr_d;
    logic [127:0] data_q, data_d;
    logic         mode_q, mode_d;
    logic         accept;

    logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;
    logic [COLS_PER_CYCLE-1:0][1:0]  lane_col;

    genvar l;
    for (l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        assign lane_col[l] = 2'((int'(cnt_q) * COLS_PER_CYCLE) + l);
        assign lane_in[l]  = data_q[{lane_col[l], 5'd0} +: 32];
        mix_col u_col (
            .inv_i (mode_q),
            .col_i (lane_in[l]),
            .col_o (lane_out[l])
        );
    end

    assign in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        mode_d  = mode_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
        end else if (accept) begin
            hdr_d  = in_data[131:128];
            data_d = in_data[127:0];
            mode_d = in_mode;
            cnt_d  = 2'd0;
            if (in_data[131:128] == 4'd0)
                state_d = S_IDLE;
            else if (in_data[131:128] == BYPASS_HDR)
                state_d = S_DONE;
            else
                state_d = S_BUSY;
        end else begin
            case (state_q)
                S_BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++)
                        data_d[{lane_col[i], 5'd0} +: 32] = lane_out[i];
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'(N - 1))
                        state_d = S_DONE;
                end
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            hdr_q   <= 4'd0;
            data_q  <= 128'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_valid ? {hdr_q, data_q} : 132'd0;
endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: a 1-column and a 4-column engine checked against
// a GF(2^8) matrix-product reference model.
module tb_mix_columns_iter;
    logic         clk = 1'b0;
    logic         n_rst, flush, in_valid, in_mode, out_ready, sel;
    logic [131:0] in_data;
    logic         a_ir, a_ov, a_busy, b_ir, b_ov, b_busy;
    logic [131:0] a_od, b_od;
    logic         in_ready_s, out_valid_s, busy_s;
    logic [131:0] out_data_s;
    int checks = 0, failures = 0;

    localparam int FWD[4] = '{2, 3, 1, 1};
    localparam int INV[4] = '{14, 11, 13, 9};

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) dut_c1 (
        .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid & ~sel),
        .in_ready(a_ir), .in_mode(in_mode), .in_data(in_data), .out_valid(a_ov),
        .out_ready(out_ready & ~sel), .out_data(a_od), .busy(a_busy));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) dut_c4 (
        .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid & sel),
        .in_ready(b_ir), .in_mode(in_mode), .in_data(in_data), .out_valid(b_ov),
        .out_ready(out_ready & sel), .out_data(b_od), .busy(b_busy));

    assign in_ready_s  = sel ? b_ir   : a_ir;
    assign out_valid_s = sel ? b_ov   : a_ov;
    assign busy_s      = sel ? b_busy : a_busy;
    assign out_data_s  = sel ? b_od   : a_od;

    function automatic logic [7:0] gmul(input int k, input logic [7:0] x);
        logic [7:0] acc = 8'd0;
        logic [7:0] p = x;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc ^= p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] d, input logic inv);
        logic [127:0] res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc = 8'd0;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(inv ? INV[(k - r + 4) % 4] : FWD[(k - r + 4) % 4], d[c*32 + k*8 +: 8]);
                res[c*32 + r*8 +: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one packet, measure edges after the accept edge until out_valid, then drain it.
    task automatic xfer(input logic [3:0] h, input logic [127:0] d, input logic m,
                        output int edges, output logic [131:0] q, output logic got);
        @(negedge clk);
        in_valid = 1'b1; in_data = {h, d}; in_mode = m; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = {4'($urandom), rnd128()}; in_mode = 1'($urandom);
        edges = 0; got = 1'b0; q = '0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_s) begin got = 1'b1; break; end
            @(posedge clk); #1; edges++;
        end
        q = out_data_s;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
        in_data = '0; sel = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            checks++;
            if ({in_ready_s, out_valid_s, busy_s} !== 3'b100 || out_data_s !== '0) begin
                failures++;
                $display("FAIL reset sel=%0d: rdy/vld/busy=%b data=%h, want 100 data=0",
                         sel, {in_ready_s, out_valid_s, busy_s}, out_data_s);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_known();
        int e; logic [131:0] q; logic g; logic [127:0] d;
        sel = 1'b0; d = {rnd128() >> 32, 32'h455313db};
        xfer(4'd1, d, 1'b0, e, q, g);
        checks++;
        if (!g || e != 4 || q[31:0] !== 32'hbca14d8e || q !== {4'd1, mix_ref(d, 1'b0)}) begin
            failures++;
            $display("FAIL known_fwd_c1: got=%0d edges=%0d q=%h, want edges=4 col0=bca14d8e q=%h",
                     g, e, q, {4'd1, mix_ref(d, 1'b0)});
        end
        sel = 1'b1; d = {rnd128() >> 32, 32'hbca14d8e};
        xfer(4'd2, d, 1'b1, e, q, g);
        checks++;
        if (!g || e != 1 || q[31:0] !== 32'h455313db || q !== {4'd2, mix_ref(d, 1'b1)}) begin
            failures++;
            $display("FAIL known_inv_c4: got=%0d edges=%0d q=%h, want edges=1 col0=455313db", g, e, q);
        end
        d = {rnd128() >> 32, 32'h5c220af2};
        xfer(4'd3, d, 1'b0, e, q, g);
        checks++;
        if (!g || e != 1 || q[31:0] !== 32'h9d58dc9f) begin
            failures++;
            $display("FAIL known_fwd_c4: got=%0d edges=%0d col0=%h, want edges=1 col0=9d58dc9f", g, e, q[31:0]);
        end
        sel = 1'b0;
    endtask

    task automatic test_identity();
        int e; logic [131:0] q; logic g;
        logic [127:0] d = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;
        for (int s = 0; s < 2; s++)
            for (int m = 0; m < 2; m++) begin
                sel = s[0];
                xfer(4'd5, d, m[0], e, q, g);
                checks++;
                if (!g || q !== {4'd5, d}) begin
                    failures++;
                    $display("FAIL identity sel=%0d mode=%0d: q=%h, want %h", s, m, q, {4'd5, d});
                end
            end
        sel = 1'b0;
    endtask

    task automatic test_random();
        int e; logic [131:0] q, exp; logic g; logic [127:0] d; logic [3:0] h; logic m;
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom); h = 4'($urandom_range(1, 15)); m = 1'($urandom); d = rnd128();
            exp = {h, (h == 4'd10) ? d : mix_ref(d, m)};
            xfer(h, d, m, e, q, g);
            checks++;
            if (!g || q !== exp || e != ((h == 4'd10) ? 0 : (sel ? 1 : 4))) begin
                failures++;
                $display("FAIL random[%0d] sel=%0d hdr=%0d mode=%0d: got=%0d edges=%0d q=%h, want %h",
                         i, sel, h, m, g, e, q, exp);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_bypass_drop();
        int e; logic [131:0] q; logic g; logic [127:0] d = rnd128(); logic bad = 1'b0;
        sel = 1'b0;
        xfer(4'd10, d, 1'b0, e, q, g);
        checks++;
        if (!g || e != 0 || q !== {4'd10, d}) begin
            failures++;
            $display("FAIL bypass: got=%0d edges=%0d q=%h, want edges=0 q=%h", g, e, q, {4'd10, d});
        end
        @(negedge clk); in_valid = 1'b1; in_data = {4'd0, rnd128()}; in_mode = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_s || !in_ready_s) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL drop_hdr0: saw out_valid or in_ready low, want no output and in_ready=1");
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d = rnd128(), d2 = rnd128(); logic [131:0] snap; logic bad = 1'b0; logic g = 1'b0;
        sel = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = {4'd7, d}; in_mode = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_s) begin g = 1'b1; break; end
            @(posedge clk); #1;
        end
        snap = out_data_s;
        checks++;
        if (!g || snap !== {4'd7, mix_ref(d, 1'b1)}) begin
            failures++;
            $display("FAIL stall_result: got=%0d q=%h, want %h", g, snap, {4'd7, mix_ref(d, 1'b1)});
        end
        repeat (5) begin
            @(negedge clk);
            if (out_data_s !== snap || in_ready_s || !out_valid_s) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL stall_hold: out_data changed or in_ready high while stalled");
        end
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_data = {4'd10, d2};
        #1;
        checks++;
        if (in_ready_s !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: in_ready=%b, want 1", in_ready_s);
        end
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid_s !== 1'b1 || out_data_s !== {4'd10, d2}) begin
            failures++;
            $display("FAIL b2b_load: vld=%b q=%h, want 1 q=%h", out_valid_s, out_data_s, {4'd10, d2});
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic bad = 1'b0;
        sel = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = {4'd4, rnd128()}; in_mode = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_data = {4'd10, rnd128()};
        #1;
        checks++;
        if (in_ready_s !== 1'b0 || busy_s !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready: in_ready=%b busy=%b, want 0 1", in_ready_s, busy_s);
        end
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid_s !== 1'b0 || busy_s !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: vld=%b busy=%b, want 0 0", out_valid_s, busy_s);
        end
        repeat (8) begin
            @(negedge clk);
            if (out_valid_s || busy_s) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL flush_quiet: output or busy appeared after flush");
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = {4'd10, rnd128()}; in_mode = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        #2; n_rst = 1'b0; #1;
        checks++;
        if (out_valid_s !== 1'b0 || out_data_s !== '0 || busy_s !== 1'b0 || in_ready_s !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: vld=%b busy=%b rdy=%b q=%h, want 0 0 1 0",
                     out_valid_s, busy_s, in_ready_s, out_data_s);
        end
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_known();
        test_identity();
        test_random();
        test_bypass_drop();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
